hb_mmio_ports: RTL and testbench

Parametrised memory-mapped I/O port block for the Hummingbird CPU. It replaces the fixed odev0/odev1/idev0 latches and their 74138 decode. It decodes one IO page of the 12-bit IO address space. It provides N_OUT output channels with valid/ack handshakes and N_IN input channels with valid/ready capture. Status registers and sticky overrun flags are CPU-readable. It sits on the CPU data bus beside RAM; the top level performs the tri-state using rd_drive.

---
 rtl/hb_mmio_ports.sv | 187 ++++++++++++++++++
 tb/tb_hb_mmio_ports.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_mmio_ports.sv
// hb_mmio_ports
//   Memory-mapped I/O port block for the Hummingbird CPU. It decodes one
//   16-register page of the IO address space. It provides N_OUT output
//   channels with a valid/ack handshake and N_IN input channels with a
//   valid/ready capture. It also holds readable status registers and sticky
//   overrun flags. Tri-stating the CPU bus is left to the top level, which
//   uses rd_drive to enable it.
//
//   Ports
//     clk, rst_bar               system clock, async active-low reset
//     io_address                 CPU IO address; [ADDR_W-1:4] page, [3:0] register
//     cs_bar, we_bar, oe_bar     active-low chip select, write and read strobes
//     wr_data                    CPU write data
//     rd_data, rd_drive          read data (0 when not driving), bus-drive enable
//     out_data/out_valid/out_ack output channels, DATA_W bits per channel
//     in_data/in_valid/in_ready  input channels, DATA_W bits per channel
//
//   Register map (idx = io_address[3:0])
//     0..3  OUT[i] data      write loads the channel, read returns it
//     4..7  IN[i] data       read returns the captured word and frees the slot
//     8     OUT status       {out_ovr[3:0], out_valid[3:0]}
//     9     IN status        {in_ovr[3:0], in_full[3:0]}
//     10    CLR              write-1-to-clear: [3:0] in_ovr, [7:4] out_ovr
//     other                  reads 0, writes ignored

module hb_mmio_ports #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 12,
    parameter logic [ADDR_W-5:0] PAGE   = {(ADDR_W-4){1'b1}},
    parameter int                N_OUT  = 2,
    parameter int                N_IN   = 1
) (
    input  logic                    clk,
    input  logic                    rst_bar,
    input  logic [ADDR_W-1:0]       io_address,
    input  logic                    cs_bar,
    input  logic                    we_bar,
    input  logic                    oe_bar,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_drive,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ack,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready
);

    localparam logic [3:0] IDX_OUT_STAT = 4'd8;
    localparam logic [3:0] IDX_IN_STAT  = 4'd9;
    localparam logic [3:0] IDX_CLR      = 4'd10;

    logic [3:0] idx;
    logic       sel;
    logic       wr_en;
    logic       rd_en;

    logic [DATA_W-1:0] out_reg [N_OUT];
    logic [N_OUT-1:0]  out_ovr;
    logic [N_OUT-1:0]  out_wr;
    logic [N_OUT-1:0]  out_ovr_set;
    logic [N_OUT-1:0]  out_ovr_clr;

    logic [DATA_W-1:0] in_word [N_IN];
    logic [N_IN-1:0]   in_full;
    logic [N_IN-1:0]   in_ovr;
    logic [N_IN-1:0]   in_rd;
    logic [N_IN-1:0]   in_cap;
    logic [N_IN-1:0]   in_ovr_set;
    logic [N_IN-1:0]   in_ovr_clr;

    logic [3:0] out_valid_4;
    logic [3:0] out_ovr_4;
    logic [3:0] in_full_4;
    logic [3:0] in_ovr_4;

    assign idx   = io_address[3:0];
    assign sel   = ~cs_bar & (io_address[ADDR_W-1:4] == PAGE);
    assign wr_en = sel & ~we_bar;
    // A cycle with both strobes low is a write; it never drives the bus.
    assign rd_en = sel & ~oe_bar & we_bar;

    // Channel-level strobes decoded from the CPU access.
    always_comb begin
        out_wr      = '0;
        out_ovr_set = '0;
        out_ovr_clr = '0;
        for (int i = 0; i < N_OUT; i++) begin
            out_wr[i]      = wr_en & (idx == 4'(i));
            // An ack on the same edge means the old word was consumed, so no overrun.
            out_ovr_set[i] = out_wr[i] & out_valid[i] & ~out_ack[i];
            out_ovr_clr[i] = wr_en & (idx == IDX_CLR) & wr_data[4+i];
        end
    end

    always_comb begin
        in_rd      = '0;
        in_cap     = '0;
        in_ovr_set = '0;
        in_ovr_clr = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_rd[i]      = rd_en & (idx == 4'(4 + i));
            // Capture and drop use only the registered full flag. A read that
            // commits on the same edge does not open the slot early.
            in_cap[i]     = in_valid[i] & ~in_full[i];
            in_ovr_set[i] = in_valid[i] & in_full[i];
            in_ovr_clr[i] = wr_en & (idx == IDX_CLR) & wr_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            for (int i = 0; i < N_OUT; i++) begin
                out_reg[i] <= '0;
            end
            out_valid <= '0;
            out_ovr   <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (out_wr[i]) begin
                    out_reg[i]   <= wr_data;
                    out_valid[i] <= 1'b1;
                end else if (out_ack[i]) begin
                    out_valid[i] <= 1'b0;
                end
                // A set wins over a clear on the same edge.
                out_ovr[i] <= out_ovr_set[i] | (out_ovr[i] & ~out_ovr_clr[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            for (int i = 0; i < N_IN; i++) begin
                in_word[i] <= '0;
            end
            in_full <= '0;
            in_ovr  <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_cap[i]) begin
                    in_word[i] <= in_data[i*DATA_W +: DATA_W];
                    in_full[i] <= 1'b1;
                end else if (in_rd[i]) begin
                    in_full[i] <= 1'b0;
                end
                in_ovr[i] <= in_ovr_set[i] | (in_ovr[i] & ~in_ovr_clr[i]);
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out_flat
        assign out_data[g*DATA_W +: DATA_W] = out_reg[g];
    end

    assign in_ready = ~in_full;

    // Status fields are always 4 bits wide. Bits for channels that do not exist read 0.
    always_comb begin
        out_valid_4              = '0;
        out_ovr_4                = '0;
        in_full_4                = '0;
        in_ovr_4                 = '0;
        out_valid_4[N_OUT-1:0]   = out_valid;
        out_ovr_4[N_OUT-1:0]     = out_ovr;
        in_full_4[N_IN-1:0]      = in_full;
        in_ovr_4[N_IN-1:0]       = in_ovr;
    end

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (idx == 4'(i)) rd_data = out_reg[i];
            end
            for (int i = 0; i < N_IN; i++) begin
                if (idx == 4'(4 + i)) rd_data = in_word[i];
            end
            if (idx == IDX_OUT_STAT) rd_data = DATA_W'({out_ovr_4, out_valid_4});
            if (idx == IDX_IN_STAT)  rd_data = DATA_W'({in_ovr_4, in_full_4});
        end
    end

    assign rd_drive = rd_en;

endmodule

// File: tb/tb_hb_mmio_ports.sv
module tb_hb_mmio_ports;

    logic        clk = 1'b0;
    logic        rst_bar;
    logic [11:0] io_address;
    logic        cs_bar, we_bar, oe_bar;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rd_drive;
    logic [15:0] out_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ack;
    logic [7:0]  in_data;
    logic [0:0]  in_valid;
    logic [0:0]  in_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hb_mmio_ports dut (
        .clk        (clk),
        .rst_bar    (rst_bar),
        .io_address (io_address),
        .cs_bar     (cs_bar),
        .we_bar     (we_bar),
        .oe_bar     (oe_bar),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_drive   (rd_drive),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready)
    );

    // Reference state, as the register map describes it.
    logic [7:0] m_od [2];
    logic [1:0] m_ov, m_oo;
    logic [7:0] m_iw;
    logic       m_if, m_io;

    function automatic logic m_sel();
        return !cs_bar && io_address[11:4] == 8'hFF;
    endfunction

    function automatic logic m_rd();
        return m_sel() && !oe_bar && we_bar;
    endfunction

    function automatic logic m_wr();
        return m_sel() && !we_bar;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] r);
        case (r)
            4'd0:    return m_od[0];
            4'd1:    return m_od[1];
            4'd4:    return m_iw;
            4'd8:    return {2'b00, m_oo, 2'b00, m_ov};
            4'd9:    return {3'b000, m_io, 3'b000, m_if};
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_od[0] = 8'h00; m_od[1] = 8'h00;
        m_ov = 2'b00; m_oo = 2'b00;
        m_iw = 8'h00; m_if = 1'b0; m_io = 1'b0;
    endtask

    always @(negedge rst_bar) m_reset();

    always @(posedge clk) begin
        if (rst_bar) begin
            logic [3:0] r;
            logic       wr, rd;
            r  = io_address[3:0];
            wr = m_wr();
            rd = m_rd();
            for (int i = 0; i < 2; i++) begin
                logic set_o, clr_o;
                set_o = 1'b0;
                clr_o = wr && r == 4'd10 && wr_data[4+i];
                if (wr && r == 4'(i)) begin
                    set_o   = m_ov[i] && !out_ack[i];
                    m_od[i] = wr_data;
                    m_ov[i] = 1'b1;
                end else if (out_ack[i]) begin
                    m_ov[i] = 1'b0;
                end
                m_oo[i] = set_o || (m_oo[i] && !clr_o);
            end
            begin
                logic drop, clr_i;
                drop  = in_valid[0] && m_if;
                clr_i = wr && r == 4'd10 && wr_data[0];
                if (in_valid[0] && !m_if) begin
                    m_iw = in_data;
                    m_if = 1'b1;
                end else if (rd && r == 4'd4) begin
                    m_if = 1'b0;
                end
                m_io = drop || (m_io && !clr_i);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_bar === 1'b1) begin
            chk("cyc_out_data",  32'(out_data),  32'({m_od[1], m_od[0]}));
            chk("cyc_out_valid", 32'(out_valid), 32'(m_ov));
            chk("cyc_in_ready",  32'(in_ready),  32'(!m_if));
            chk("cyc_rd_drive",  32'(rd_drive),  32'(m_rd()));
            chk("cyc_rd_data",   32'(rd_data),   32'(m_rd() ? m_read(io_address[3:0]) : 8'h00));
        end
    end

    task automatic idle();
        cs_bar = 1'b1; we_bar = 1'b1; oe_bar = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [11:0] a, input logic [7:0] d);
        io_address = a; wr_data = d;
        cs_bar = 1'b0; we_bar = 1'b0; oe_bar = 1'b1;
        cyc();
        idle();
    endtask

    task automatic cpu_rd(input logic [11:0] a, input logic [7:0] exp, input string nm);
        io_address = a;
        cs_bar = 1'b0; we_bar = 1'b1; oe_bar = 1'b0;
        @(negedge clk);
        chk(nm, 32'(rd_data), 32'(exp));
        chk({nm, "_drv"}, 32'(rd_drive), 32'd1);
        cyc();
        idle();
    endtask

    initial begin
        rst_bar = 1'b0;
        io_address = 12'h123; wr_data = 8'h00;
        out_ack = 2'b00; in_data = 8'h00; in_valid = 1'b0;
        idle();
        m_reset();
        repeat (3) cyc();
        rst_bar = 1'b1;
        cyc();

        // Defaults after reset
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        io_address = 12'h123; cs_bar = 1'b0; oe_bar = 1'b0;
        #1;
        chk("offpage_drive", 32'(rd_drive), 32'h0);
        chk("offpage_data",  32'(rd_data),  32'h0);
        cyc();
        idle();
        cpu_rd(12'hFF8, 8'h00, "rst_reg8");
        cpu_rd(12'hFF9, 8'h00, "rst_reg9");

        // Output channel 1: load, overrun, ack, clear
        cpu_wr(12'hFF1, 8'hA5);
        chk("o1_data_a5", 32'(out_data[15:8]), 32'hA5);
        chk("o1_valid",   32'(out_valid),      32'h2);
        cpu_rd(12'hFF8, 8'h02, "reg8_after_load");
        cpu_wr(12'hFF1, 8'h3C);
        chk("o1_data_3c", 32'(out_data[15:8]), 32'h3C);
        cpu_rd(12'hFF8, 8'h22, "reg8_overrun");
        out_ack = 2'b10;
        cyc();
        out_ack = 2'b00;
        cpu_rd(12'hFF8, 8'h20, "reg8_acked");
        chk("o1_data_held", 32'(out_data[15:8]), 32'h3C);
        cpu_wr(12'hFFA, 8'h20);
        cpu_rd(12'hFF8, 8'h00, "reg8_cleared");

        // Write coincident with ack: no overrun
        cpu_wr(12'hFF0, 8'h11);
        out_ack = 2'b01;
        cpu_wr(12'hFF0, 8'h22);
        out_ack = 2'b00;
        chk("o0_data_22", 32'(out_data[7:0]), 32'h22);
        chk("o0_valid",   32'(out_valid),     32'h1);
        cpu_rd(12'hFF8, 8'h01, "reg8_ack_write");
        cpu_rd(12'hFF0, 8'h22, "reg0_read");

        // Input capture and read
        in_valid = 1'b1; in_data = 8'h77;
        cyc();
        in_valid = 1'b0;
        chk("in_ready_full", 32'(in_ready), 32'h0);
        cpu_rd(12'hFF9, 8'h01, "reg9_full");
        cpu_rd(12'hFF4, 8'h77, "reg4_77");
        chk("in_ready_freed", 32'(in_ready), 32'h1);

        // Drop while full, with a coincident read
        in_valid = 1'b1; in_data = 8'h55;
        cyc();
        in_data = 8'h99;
        cpu_rd(12'hFF4, 8'h55, "reg4_coincident");
        in_valid = 1'b0;
        chk("in_ready_after_drop", 32'(in_ready), 32'h1);
        cpu_rd(12'hFF9, 8'h10, "reg9_overrun");
        cpu_wr(12'hFFA, 8'h01);
        cpu_rd(12'hFF9, 8'h00, "reg9_cleared");
        cpu_rd(12'hFF4, 8'h55, "reg4_not_overwritten");

        // Async reset mid-cycle
        in_valid = 1'b1; in_data = 8'h66;
        cyc();
        in_valid = 1'b0;
        #2;
        rst_bar = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_out_data",  32'(out_data),  32'h0);
        chk("arst_in_ready",  32'(in_ready),  32'h1);
        chk("arst_rd_drive",  32'(rd_drive),  32'h0);
        cyc();
        rst_bar = 1'b1;
        cyc();

        // Randomised traffic against the reference state
        for (int n = 0; n < 3000; n++) begin
            int s;
            cs_bar = ($urandom_range(0, 9) < 3);
            io_address = ($urandom_range(0, 9) < 8) ? {8'hFF, 4'($urandom_range(0, 15))}
                                                      : 12'($urandom);
            s = $urandom_range(0, 3);
            we_bar = !(s == 1 || s == 3);
            oe_bar = !(s == 2 || s == 3);
            wr_data  = 8'($urandom);
            out_ack  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            in_valid = ($urandom_range(0, 4) < 2);
            in_data  = 8'($urandom);
            if (n == 1500) begin
                rst_bar = 1'b0;
                cyc();
                rst_bar = 1'b1;
            end
            cyc();
        end
        idle();
        out_ack = 2'b00; in_valid = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
